// File: rtl/srff_sr_checker.sv
// srff_sr_checker: cycle-accurate reference checker for a synchronous-reset SR flop.
// Optional macro SRFF_CHK_QBAR_EN enables the q_bar complement check.
module srff_sr_checker #(
  parameter int CNT_W     = 8,
  parameter int ERR_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             q_bar,
  output logic             mismatch,
  output logic             illegal,
  output logic             qbar_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [1:0]       state,
  output logic             fail
);
  typedef enum logic [1:0] {UNKNOWN = 2'b00, TRACK = 2'b01, FAIL = 2'b10} state_t;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(ERR_LIMIT);
  state_t           state_q, state_d;
  logic             exp_q, exp_d, exp_x_q, exp_x_d;
  logic             mismatch_q, mismatch_d, illegal_q, illegal_d, qbar_err_q, qbar_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, illegal_cnt_q, illegal_cnt_d;
  logic [CNT_W:0]   err_sum, ill_sum;
`ifndef SRFF_CHK_QBAR_EN
  logic unused_q_bar;
  assign unused_q_bar = q_bar;
`endif
  // exp_x_q marks the model unknown after an s=r=1 command until a 01/10 reloads it
  always_comb begin
    mismatch_d    = en & ~exp_x_q & (q != exp_q);
    exp_d         = (s ^ r) ? s : (mismatch_d ? q : exp_q);
    exp_x_d       = (s & r) | (exp_x_q & ~(s ^ r));
    illegal_d     = en & s & r;
`ifdef SRFF_CHK_QBAR_EN
    qbar_err_d    = en & (q_bar == q);
`else
    qbar_err_d    = 1'b0;
`endif
    err_sum       = {1'b0, err_cnt_q} + {{CNT_W{1'b0}}, mismatch_d} + {{CNT_W{1'b0}}, qbar_err_d};
    ill_sum       = {1'b0, illegal_cnt_q} + {{CNT_W{1'b0}}, illegal_d};
    err_cnt_d     = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    illegal_cnt_d = ill_sum[CNT_W] ? '1 : ill_sum[CNT_W-1:0];
    state_d       = (state_q == FAIL || err_cnt_q >= LIM) ? FAIL :
                    (state_q == TRACK && s && r)         ? UNKNOWN :
                    (state_q == UNKNOWN && (s ^ r))      ? TRACK : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= TRACK;
      exp_q         <= 1'b0;
      exp_x_q       <= 1'b0;
      mismatch_q    <= 1'b0;
      illegal_q     <= 1'b0;
      qbar_err_q    <= 1'b0;
      err_cnt_q     <= '0;
      illegal_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      exp_x_q       <= exp_x_d;
      mismatch_q    <= mismatch_d;
      illegal_q     <= illegal_d;
      qbar_err_q    <= qbar_err_d;
      err_cnt_q     <= err_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end
  assign mismatch    = mismatch_q;
  assign illegal     = illegal_q;
  assign qbar_err    = qbar_err_q;
  assign err_cnt     = err_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
  assign state       = state_q;
  assign fail        = (state_q == FAIL);
endmodule

// File: tb/tb_srff_sr_checker.sv
// tb_srff_sr_checker: directed table, complement sequence and randomized model check.
module tb_srff_sr_checker;
  localparam int CW = 4, LIM = 4, MAX = 15;
`ifdef SRFF_CHK_QBAR_EN
  localparam int QB = 1;
`else
  localparam int QB = 0;
`endif
  logic clk = 0, rst = 0, en = 0, s = 0, r = 0, q = 0, q_bar = 1;
  logic mismatch, illegal, qbar_err, fail;
  logic [CW-1:0] err_cnt, illegal_cnt;
  logic [1:0] state;
  int n_vec = 0, n_bad = 0;
  int m_exp, m_st, m_err, m_ic;
  bit m_mis, m_ilp, m_qe;

  srff_sr_checker #(.CNT_W(CW), .ERR_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q), .q_bar(q_bar),
    .mismatch(mismatch), .illegal(illegal), .qbar_err(qbar_err),
    .err_cnt(err_cnt), .illegal_cnt(illegal_cnt), .state(state), .fail(fail));

  always #5 clk = ~clk;

  typedef struct {
    logic rst, en, s, r, q;
    logic mis, ill;
    int   err, ic, st;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(input logic a, e, ss, rr, qq, mi, il, input int er, ic, st);
    vec_t t;
    t.rst = a; t.en = e; t.s = ss; t.r = rr; t.q = qq;
    t.mis = mi; t.ill = il; t.err = er; t.ic = ic; t.st = st;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, e, ss, rr, qq, qb);
    @(negedge clk);
    rst = a; en = e; s = ss; r = rr; q = qq; q_bar = qb;
    @(posedge clk);
    #1;
  endtask

  // Model: exp is 0/1 or -1 when unknown; states 0=UNKNOWN 1=TRACK 2=FAIL
  task automatic model_step();
    int pe;
    if (!rst) begin
      m_exp = 0; m_st = 1; m_err = 0; m_ic = 0; m_mis = 0; m_ilp = 0; m_qe = 0;
    end else begin
      pe = m_err;
      m_mis = en && m_exp >= 0 && int'(q) != m_exp;
      if (m_mis) m_exp = int'(q);
      if (s && !r) m_exp = 1;
      else if (!s && r) m_exp = 0;
      else if (s && r) m_exp = -1;
      m_ilp = en && s && r;
      m_qe  = QB == 1 && en && q_bar == q;
      m_ic  = (m_ic + m_ilp > MAX) ? MAX : m_ic + m_ilp;
      m_err = (m_err + m_mis + m_qe > MAX) ? MAX : m_err + m_mis + m_qe;
      if (m_st != 2) begin
        if (pe >= LIM) m_st = 2;
        else if (m_st == 1 && s && r) m_st = 0;
        else if (m_st == 0 && s != r) m_st = 1;
      end
    end
  endtask

  initial begin
    logic fq, rr, e, ss, rv, qq, qb;
    int k;
    tbl.push_back(v(0,1,0,0,0, 0,0,0,0,1));
    for (int i = 0; i < 4; i++) tbl.push_back(v(1,1,0,0,0, 0,0,0,0,1));
    tbl.push_back(v(1,1,1,0,0, 0,0,0,0,1));
    tbl.push_back(v(1,1,0,0,1, 0,0,0,0,1));
    tbl.push_back(v(1,1,0,1,1, 0,0,0,0,1));
    tbl.push_back(v(1,1,0,0,0, 0,0,0,0,1));
    tbl.push_back(v(1,1,0,0,1, 1,0,1,0,1));
    tbl.push_back(v(1,1,0,0,1, 0,0,1,0,1));
    tbl.push_back(v(1,1,1,1,1, 0,1,1,1,0));
    tbl.push_back(v(1,1,0,0,1, 0,0,1,1,0));
    tbl.push_back(v(1,1,1,0,0, 0,0,1,1,1));
    tbl.push_back(v(1,1,0,0,1, 0,0,1,1,1));
    tbl.push_back(v(1,0,0,1,1, 0,0,1,1,1));
    tbl.push_back(v(1,0,0,0,1, 0,0,1,1,1));
    tbl.push_back(v(1,1,0,0,0, 0,0,1,1,1));
    tbl.push_back(v(1,0,1,1,0, 0,0,1,1,0));
    tbl.push_back(v(1,1,1,0,0, 0,0,1,1,1));
    tbl.push_back(v(1,1,0,0,1, 0,0,1,1,1));
    tbl.push_back(v(1,1,0,0,0, 1,0,2,1,1));
    tbl.push_back(v(1,1,0,0,1, 1,0,3,1,1));
    tbl.push_back(v(1,1,0,0,0, 1,0,4,1,1));
    tbl.push_back(v(1,1,0,0,0, 0,0,4,1,2));
    tbl.push_back(v(1,1,0,0,1, 1,0,5,1,2));
    tbl.push_back(v(1,1,1,1,1, 0,1,5,2,2));
    tbl.push_back(v(1,1,0,0,0, 0,0,5,2,2));
    tbl.push_back(v(1,1,0,1,0, 0,0,5,2,2));
    tbl.push_back(v(1,1,0,0,1, 1,0,6,2,2));
    tbl.push_back(v(0,1,1,1,1, 0,0,0,0,1));
    tbl.push_back(v(1,1,0,0,0, 0,0,0,0,1));
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].s, tbl[i].r, tbl[i].q, ~tbl[i].q);
      chk($sformatf("tbl%0d_mismatch", i), 32'(mismatch), 32'(tbl[i].mis));
      chk($sformatf("tbl%0d_illegal", i), 32'(illegal), 32'(tbl[i].ill));
      chk($sformatf("tbl%0d_qbar_err", i), 32'(qbar_err), 0);
      chk($sformatf("tbl%0d_err_cnt", i), 32'(err_cnt), tbl[i].err);
      chk($sformatf("tbl%0d_illegal_cnt", i), 32'(illegal_cnt), tbl[i].ic);
      chk($sformatf("tbl%0d_state", i), 32'(state), tbl[i].st);
      chk($sformatf("tbl%0d_fail", i), 32'(fail), 32'(tbl[i].st == 2));
    end
    // complement check: TRACK, exp=0, counts zero here
    drive(1,1,0,0,0,0);
    chk("cmp_qbar_err", 32'(qbar_err), QB);
    chk("cmp_err_cnt", 32'(err_cnt), QB);
    drive(1,1,0,0,0,1);
    chk("cmp_ok_qbar_err", 32'(qbar_err), 0);
    drive(1,0,0,0,0,0);
    chk("cmp_en0_qbar_err", 32'(qbar_err), 0);
    chk("cmp_en0_err_cnt", 32'(err_cnt), QB);
    drive(1,1,0,0,1,1);
    chk("both_mismatch", 32'(mismatch), 1);
    chk("both_qbar_err", 32'(qbar_err), QB);
    chk("both_err_cnt", 32'(err_cnt), 1 + 2 * QB);
    // randomized run against the model, with a behavioural flop driving q
    fq = 0;
    for (int i = 0; i < 3000; i++) begin
      rr = (i != 0) && ($urandom_range(0, 199) != 0);
      e  = $urandom_range(0, 7) != 0;
      k  = $urandom_range(0, 9);
      ss = (k == 5 || k == 6 || k == 9);
      rv = (k == 7 || k == 8 || k == 9);
      qq = fq ^ ($urandom_range(0, 19) == 0);
      qb = ~qq ^ ($urandom_range(0, 19) == 0);
      drive(rr, e, ss, rv, qq, qb);
      model_step();
      chk($sformatf("rnd%0d_mismatch", i), 32'(mismatch), 32'(m_mis));
      chk($sformatf("rnd%0d_illegal", i), 32'(illegal), 32'(m_ilp));
      chk($sformatf("rnd%0d_qbar_err", i), 32'(qbar_err), 32'(m_qe));
      chk($sformatf("rnd%0d_err_cnt", i), 32'(err_cnt), m_err);
      chk($sformatf("rnd%0d_illegal_cnt", i), 32'(illegal_cnt), m_ic);
      chk($sformatf("rnd%0d_state", i), 32'(state), m_st);
      chk($sformatf("rnd%0d_fail", i), 32'(fail), 32'(m_st == 2));
      if (!rr) fq = 0;
      else if (ss && !rv) fq = 1;
      else if (!ss && rv) fq = 0;
      else if (ss && rv) fq = logic'($urandom_range(0, 1));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
